// File: rtl/if_id_queue.sv
// Two-entry fetch-to-decode instruction queue replacing the bare IF/ID latch.
// Absorbs decode stalls, drains on branch redirect, and stops fetch once a halt is queued.
module if_id_queue #(
    parameter int          N   = 16,
    parameter logic [15:0] NOP = 16'h0800
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] instruction_in,
    input  logic [N-1:0] pcplus2_in,
    input  logic         halt_in,
    input  logic         flush,
    input  logic         id_stall,
    output logic         fetch_ready,
    output logic         valid_out,
    output logic [N-1:0] instruction_out,
    output logic [N-1:0] pcplus2_out,
    output logic         halt_out,
    output logic         err
);

    logic [1:0][N-1:0] instr_q, instr_d;
    logic [1:0][N-1:0] pc_q, pc_d;
    logic [1:0]        halt_q, halt_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              halt_seen_q, halt_seen_d;
    logic              err_q, err_d;
    logic              push, pop;

    always_comb begin
        fetch_ready     = (count_q != 2'd2) && !halt_seen_q;
        valid_out       = (count_q != 2'd0);
        instruction_out = N'(NOP);
        pcplus2_out     = '0;
        halt_out        = 1'b0;
        if (valid_out) begin
            instruction_out = instr_q[rd_ptr_q];
            pcplus2_out     = pc_q[rd_ptr_q];
            halt_out        = halt_q[rd_ptr_q];
        end
        err  = err_q;
        push = in_valid && fetch_ready && !flush;
        pop  = valid_out && !id_stall && !flush;
    end

    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        halt_d      = halt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        // A word dropped while blocked by a queued halt is expected, not a violation.
        err_d       = err_q || (in_valid && !fetch_ready && !flush && !halt_seen_q);
        if (flush) begin
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            count_d     = 2'd0;
            halt_seen_d = 1'b0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = instruction_in;
                pc_d[wr_ptr_q]    = pcplus2_in;
                halt_d[wr_ptr_q]  = halt_in;
                wr_ptr_d          = !wr_ptr_q;
                if (halt_in) halt_seen_d = 1'b1;
            end
            if (pop) rd_ptr_d = !rd_ptr_q;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q     <= '0;
            pc_q        <= '0;
            halt_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            halt_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            halt_q      <= halt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue-based reference model updates on each edge,
// and a monitor compares every DUT output against it mid-cycle.
module tb_if_id_queue;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst, in_valid, halt_in, flush, id_stall;
    logic [15:0] instruction_in, pcplus2_in;
    logic        fetch_ready, valid_out, halt_out, err;
    logic [15:0] instruction_out, pcplus2_out;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        halt;
    } entry_t;

    entry_t exp_q[$];
    logic   m_halt = 1'b0;
    logic   m_err  = 1'b0;
    int     checks   = 0;
    int     failures = 0;
    bit     done     = 0;

    if_id_queue #(.N(16), .NOP(16'h0800)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_in(instruction_in),
        .pcplus2_in(pcplus2_in), .halt_in(halt_in), .flush(flush), .id_stall(id_stall),
        .fetch_ready(fetch_ready), .valid_out(valid_out), .instruction_out(instruction_out),
        .pcplus2_out(pcplus2_out), .halt_out(halt_out), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: a plain FIFO of entries plus the halt/err flags.
    always @(posedge clk) begin
        bit ready;
        if (rst) begin
            exp_q.delete();
            m_halt = 1'b0;
            m_err  = 1'b0;
        end else begin
            ready = (exp_q.size() < 2) && !m_halt;
            if (in_valid && !ready && !flush && !m_halt) m_err = 1'b1;
            if (flush) begin
                exp_q.delete();
                m_halt = 1'b0;
            end else begin
                if (exp_q.size() > 0 && !id_stall) void'(exp_q.pop_front());
                if (in_valid && ready) begin
                    exp_q.push_back('{instr: instruction_in, pc: pcplus2_in, halt: halt_in});
                    if (halt_in) m_halt = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare outputs mid-cycle against the model's head entry.
    initial begin
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                entry_t head;
                bit     has;
                has  = exp_q.size() > 0;
                head = has ? exp_q[0] : '0;
                check("valid_out",       {15'd0, valid_out},   {15'd0, has});
                check("instruction_out", instruction_out,      has ? head.instr : NOP);
                check("pcplus2_out",     pcplus2_out,          has ? head.pc : 16'h0);
                check("halt_out",        {15'd0, halt_out},    {15'd0, has && head.halt});
                check("fetch_ready",     {15'd0, fetch_ready}, {15'd0, exp_q.size() < 2 && !m_halt});
                check("err",             {15'd0, err},         {15'd0, m_err});
            end
        end
    end

    task automatic drive(input logic r, input logic iv, input logic [15:0] ins,
                         input logic [15:0] pc, input logic h, input logic fl, input logic st);
        @(posedge clk);
        #2;
        rst = r; in_valid = iv; instruction_in = ins; pcplus2_in = pc;
        halt_in = h; flush = fl; id_stall = st;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 16'h0, 0, 0, st);
    endtask

    initial begin
        rst = 1; in_valid = 0; instruction_in = 0; pcplus2_in = 0;
        halt_in = 0; flush = 0; id_stall = 0;
        drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        idle(2, 0);
        // stream with no stalls
        drive(0, 1, 16'h4A01, 16'h0002, 0, 0, 0);
        drive(0, 1, 16'h4A02, 16'h0004, 0, 0, 0);
        drive(0, 1, 16'h4A03, 16'h0006, 0, 0, 0);
        idle(3, 0);
        // fill while decode stalls, then release
        drive(0, 1, 16'h1111, 16'h0010, 0, 0, 1);
        drive(0, 1, 16'h2222, 16'h0012, 0, 0, 1);
        idle(3, 1);
        idle(4, 0);
        // flush while full with an incoming word
        drive(0, 1, 16'hA001, 16'h0020, 0, 0, 1);
        drive(0, 1, 16'hA002, 16'h0022, 0, 0, 1);
        drive(0, 1, 16'h3333, 16'h0024, 0, 1, 1);
        idle(3, 0);
        // halt blocks fetch until a flush
        drive(0, 1, 16'h5555, 16'h0030, 0, 0, 0);
        drive(0, 1, 16'h0000, 16'h0032, 1, 0, 0);
        drive(0, 1, 16'h6666, 16'h0034, 0, 0, 0);
        idle(4, 0);
        drive(0, 0, 16'h0, 16'h0, 0, 1, 0);
        idle(2, 0);
        // violation while full, then reset clears err
        drive(0, 1, 16'hB001, 16'h0040, 0, 0, 1);
        drive(0, 1, 16'hB002, 16'h0042, 0, 0, 1);
        drive(0, 1, 16'hBBBB, 16'h0044, 0, 0, 1);
        idle(3, 1);
        idle(3, 0);
        drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        idle(2, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic h;
            h = ($urandom_range(99) < 3);
            drive(($urandom_range(199) == 0), ($urandom_range(99) < 70),
                  h ? 16'h0000 : 16'($urandom), 16'($urandom), h,
                  ($urandom_range(99) < 6), ($urandom_range(99) < 40));
        end
        idle(3, 0);
        done = 1;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Two-entry instruction queue between the fetch stage and decode. It replaces the bare IF/ID latch.
- Captures instruction, PC+2 and the halt flag from fetch whenever instruction memory delivers.
- Presents entries to decode in order and absorbs decode stalls without re-reading memory.
- Drains on branch redirect, and blocks further fetch after a halt is queued.

Parameters:
- N, 16, datapath width of instruction and PC.
- NOP, 16'h0800, encoding driven on instruction_out when the queue is empty or flushed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch has a completed instruction this cycle (memory Done and not Stall).
- instruction_in  input  N  instruction word from fetch.
- pcplus2_in  input  N  PC+2 of that instruction.
- halt_in  input  1  fetch flags instruction_in as HALT (all zeros).
- flush  input  1  taken branch from EX/MEM; discard all queued and incoming entries.
- id_stall  input  1  decode cannot accept the head entry this cycle.
- fetch_ready  output  1  queue can accept a push; feeds the PC_enable logic.
- valid_out  output  1  head entry is valid.
- instruction_out  output  N  head instruction, or NOP when invalid.
- pcplus2_out  output  N  head PC+2, or 0 when invalid.
- halt_out  output  1  head entry is HALT; 0 when invalid.
- err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset:
  - Clock and reset: single clock clk; rst is synchronous and active-high.
  - While rst=1 at a rising edge: count=0, rd/wr pointers=0, halt_seen=0, err=0.
  - Outputs after reset: fetch_ready=1, valid_out=0, instruction_out=NOP, pcplus2_out=0, halt_out=0.
  - rst has priority over flush, push and pop. Reset mid-operation discards all entries.
- Storage:
  - 2 entries x (N + N + 1) bits, 1-bit wr_ptr and rd_ptr, 2-bit count (0..2).
  - Pointers wrap 1 -> 0.
- fetch_ready = (count != 2) & ~halt_seen. It is purely state-derived, with no combinational path from id_stall, in_valid or flush.
- push = in_valid & fetch_ready & ~flush. Writes entry[wr_ptr] and advances wr_ptr.
- pop = valid_out & ~id_stall & ~flush. Advances rd_ptr.
- Count update: push only +1; pop only -1; push and pop together, count unchanged.
- Latency:
  - An entry pushed at edge N is visible on the outputs after edge N.
  - There is no same-cycle bypass from instruction_in to instruction_out.
- Outputs:
  - Driven from entry[rd_ptr] when count != 0.
  - Otherwise NOP / 0 / 0 with valid_out=0.
- Flush:
  - At the edge: count=0, rd_ptr=wr_ptr=0, halt_seen=0.
  - An in_valid word in the flush cycle is dropped.
  - Outputs show NOP from the next cycle.
- Halt:
  - When a push carries halt_in=1, halt_seen is set at the same edge, so fetch_ready=0 from the next cycle.
  - halt_seen clears only on flush or rst, because the halt may sit on a wrong path.
  - A queued halt is popped normally; halt_out=1 while it is the head.
- Full:
  - At count=2, fetch_ready=0 and no push occurs, even if a pop happens that cycle.
  - fetch_ready re-asserts the cycle after count drops.
- Empty: pop cannot occur because valid_out=0; id_stall is a don't-care.
- Error:
  - in_valid=1 while fetch_ready=0, flush=0 and halt_seen=0 sets err.
  - err stays 1 until rst. Queue state is unaffected (word dropped).
- Flush with id_stall, or flush with push: flush wins, and the result is empty.

Test Plan:
- Reset then idle: hold rst 2 cycles, in_valid=0.
  -> valid_out=0, instruction_out=16'h0800, pcplus2_out=0, fetch_ready=1, err=0.
- Stream with no stalls: push {0x4A01,0x0002},{0x4A02,0x0004},{0x4A03,0x0006} on consecutive cycles, id_stall=0.
  -> outputs appear one cycle later in the same order; count never exceeds 1.
- Fill and stall: id_stall=1, push 0x1111 then 0x2222.
  -> fetch_ready=0 from cycle 3; release id_stall.
  -> 0x1111 then 0x2222 are output; fetch_ready returns to 1 the cycle after the first pop.
- Flush while full: queue holds 2 entries, and flush=1 with in_valid=1 and instruction_in 0x3333 in the same cycle.
  -> next cycle valid_out=0, instruction_out=0x0800; 0x3333 is never output; err=0.
- Halt: push 0x5555 then 0x0000 with halt_in=1.
  -> fetch_ready=0 next cycle; halt_out=1 when 0x0000 reaches the head.
  -> a later flush restores fetch_ready=1.
- Violation: reach count=2, drive in_valid=1 for one cycle.
  -> err=1 and stays 1; queue contents unchanged; rst clears err.
